// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: controller load/store codes,
// FSM states, access sizes and the byte-enable helper.
package load_store_unit_pkg;

  localparam int BE_WIDTH = 4;

  localparam logic [2:0] LOAD_NONE = 3'b000;
  localparam logic [2:0] LOAD_LB   = 3'b001;
  localparam logic [2:0] LOAD_LBU  = 3'b101;
  localparam logic [2:0] LOAD_LH   = 3'b010;
  localparam logic [2:0] LOAD_LHU  = 3'b110;
  localparam logic [2:0] LOAD_LW   = 3'b100;

  localparam logic [1:0] STORE_NONE = 2'b00;
  localparam logic [1:0] STORE_SB   = 2'b01;
  localparam logic [1:0] STORE_SH   = 2'b10;
  localparam logic [1:0] STORE_SW   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2
  } lsu_state_e;

  // SIZE_X marks an encoding the controller should never emit.
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } access_size_e;

  function automatic access_size_e load_size(input logic [2:0] load_type);
    case (load_type)
      LOAD_LB, LOAD_LBU: load_size = SIZE_B;
      LOAD_LH, LOAD_LHU: load_size = SIZE_H;
      LOAD_LW:           load_size = SIZE_W;
      default:           load_size = SIZE_X;
    endcase
  endfunction

  function automatic access_size_e store_size(input logic [1:0] store_type);
    case (store_type)
      STORE_SB: store_size = SIZE_B;
      STORE_SH: store_size = SIZE_H;
      STORE_SW: store_size = SIZE_W;
      default:  store_size = SIZE_X;
    endcase
  endfunction

  function automatic logic [BE_WIDTH-1:0] be_pattern(input access_size_e size,
                                                     input logic [1:0] offset);
    case (size)
      SIZE_B:  be_pattern = 4'b0001 << offset;
      SIZE_H:  be_pattern = 4'b0011 << {offset[1], 1'b0};
      default: be_pattern = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/gnt/rvalid bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import load_store_unit_pkg::*;

  // req is held with addr/we/be/wdata stable until gnt is sampled high;
  // rvalid (with rdata on loads) follows at least one cycle after gnt.
  logic                  data_req_o;
  logic                  data_gnt_i;
  logic                  data_rvalid_i;
  logic [ADDR_WIDTH-1:0] data_addr_o;
  logic                  data_we_o;
  logic [BE_WIDTH-1:0]   data_be_o;
  logic [DATA_WIDTH-1:0] data_wdata_o;
  logic [DATA_WIDTH-1:0] data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Shifts the selected byte/halfword of the read word down to bit 0 and
// sign- or zero-extends it; load_type[2] selects zero extension.
module load_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            load_type,
  input  logic [1:0]            offset,
  output logic [DATA_WIDTH-1:0] result
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = '0;
    result  = rdata;
    case (load_size(load_type))
      SIZE_B: begin
        shifted = rdata >> {offset, 3'b000};
        result  = load_type[2] ? {24'b0, shifted[7:0]}
                               : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        shifted = rdata >> {offset[1], 4'b0000};
        result  = load_type[2] ? {16'b0, shifted[15:0]}
                               : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates and captures one access,
// runs it on the req/gnt/rvalid bus and returns extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  done_o,
  output logic                  err_o,
  output lsu_state_e            state_o,
  load_store_unit_if.master     mem
);

  lsu_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [2:0]            load_type_q, load_type_d;

  logic                  is_load;
  logic                  is_store;
  access_size_e          size;
  logic                  misaligned;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] load_result;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata     (mem.data_rdata_i),
    .load_type (load_type_q),
    .offset    (addr_q[1:0]),
    .result    (load_result)
  );

  // Request decode: size, alignment and legality of the incoming controls.
  always_comb begin
    is_load    = (load_type_i != LOAD_NONE);
    is_store   = (store_type_i != STORE_NONE);
    size       = is_load ? load_size(load_type_i) : store_size(store_type_i);
    misaligned = ((size == SIZE_H) && addr_i[0]) ||
                 ((size == SIZE_W) && (addr_i[1:0] != 2'b00));
    illegal    = (is_load && is_store) || (size == SIZE_X) || misaligned;
    case (store_type_i)
      STORE_SB: wdata_rep = {4{wdata_i[7:0]}};
      STORE_SH: wdata_rep = {2{wdata_i[15:0]}};
      STORE_SW: wdata_rep = wdata_i;
      default:  wdata_rep = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_type_d = load_type_q;
    result_d    = result_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && (is_load || is_store)) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            addr_d      = addr_i;
            we_d        = is_store;
            be_d        = be_pattern(size, addr_i[1:0]);
            wdata_d     = wdata_rep;
            load_type_d = load_type_i;
            req_d       = 1'b1;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem.data_gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (mem.data_rvalid_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (!we_q) result_d = load_result;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      load_type_q <= LOAD_NONE;
      result_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_type_q <= load_type_d;
      result_q    <= result_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ready_o          = (state_q == ST_IDLE);
  assign state_o          = state_q;
  assign result_o         = result_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign mem.data_req_o   = req_q;
  assign mem.data_we_o    = we_q;
  assign mem.data_be_o    = be_q;
  assign mem.data_wdata_o = wdata_q;
  assign mem.data_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: bus-side checks per transaction and a
// result scoreboard popped on each completion pulse.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  load_type_i = 3'b000;
  logic [1:0]  store_type_i = 2'b00;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] result_o;
  logic        done_o;
  logic        err_o;
  lsu_state_e  state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_result = '0;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .load_type_i  (load_type_i),
    .store_type_i (store_type_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .result_o     (result_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .state_o      (state_o),
    .mem          (mem.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req"}, 32'(mem.data_req_o), 32'd0);
    check({tag, " ready"}, 32'(ready_o), 32'd1);
    check({tag, " done"}, 32'(done_o), 32'd0);
  endtask

  // Full transaction; gnt_delay cycles of stray rvalid are driven while in REQ.
  task automatic do_txn(input string tag, input logic [2:0] lt, input logic [1:0] st,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gnt_delay,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_result);
    int lat;
    logic [31:0] exp_addr;
    logic [31:0] popped;
    exp_addr = {addr[31:2], 2'b00};
    load_type_i = lt; store_type_i = st; addr_i = addr; wdata_i = wdata; valid_i = 1'b1;
    tick(); lat = 1;
    valid_i = 1'b0; load_type_i = 3'b000; store_type_i = 2'b00;
    check({tag, " req"}, 32'(mem.data_req_o), 32'd1);
    check({tag, " ready"}, 32'(ready_o), 32'd0);
    check({tag, " addr"}, mem.data_addr_o, exp_addr);
    check({tag, " be"}, 32'(mem.data_be_o), 32'(exp_be));
    check({tag, " we"}, 32'(mem.data_we_o), 32'(st != 2'b00));
    if (st != 2'b00) check({tag, " wdata"}, mem.data_wdata_o, exp_wdata);
    for (int i = 0; i < gnt_delay; i++) begin
      mem.data_gnt_i = 1'b0; mem.data_rvalid_i = 1'b1; mem.data_rdata_i = 32'h5A5A5A5A;
      tick(); lat++;
      check({tag, " hold req"}, 32'(mem.data_req_o), 32'd1);
      check({tag, " hold addr"}, mem.data_addr_o, exp_addr);
      check({tag, " hold be"}, 32'(mem.data_be_o), 32'(exp_be));
      check({tag, " hold done"}, 32'(done_o), 32'd0);
    end
    mem.data_gnt_i = 1'b1; mem.data_rvalid_i = 1'b0;
    tick(); lat++;
    mem.data_gnt_i = 1'b0;
    check({tag, " req drop"}, 32'(mem.data_req_o), 32'd0);
    check({tag, " state wait"}, 32'(state_o), 32'(ST_WAIT_R));
    check({tag, " early done"}, 32'(done_o), 32'd0);
    exp_q.push_back(exp_result);
    mem.data_rvalid_i = 1'b1; mem.data_rdata_i = rdata;
    tick(); lat++;
    mem.data_rvalid_i = 1'b0; mem.data_rdata_i = '0;
    check({tag, " done"}, 32'(done_o), 32'd1);
    check({tag, " ready at done"}, 32'(ready_o), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(3 + gnt_delay));
    if (exp_q.size() > 0) begin
      popped = exp_q.pop_front();
      check({tag, " result"}, result_o, popped);
    end
    model_result = exp_result;
    tick();
    check({tag, " done pulse"}, 32'(done_o), 32'd0);
    check({tag, " result hold"}, result_o, exp_result);
  endtask

  task automatic do_err(input string tag, input logic [2:0] lt, input logic [1:0] st,
                        input logic [31:0] addr);
    load_type_i = lt; store_type_i = st; addr_i = addr; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; load_type_i = 3'b000; store_type_i = 2'b00;
    check({tag, " err"}, 32'(err_o), 32'd1);
    check_idle_outputs(tag);
    tick();
    check({tag, " err pulse"}, 32'(err_o), 32'd0);
    check({tag, " req after"}, 32'(mem.data_req_o), 32'd0);
    check({tag, " ready after"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    mem.data_gnt_i = 1'b0;
    mem.data_rvalid_i = 1'b0;
    mem.data_rdata_i = '0;

    // Reset values.
    #12;
    check("rst req", 32'(mem.data_req_o), 32'd0);
    check("rst ready", 32'(ready_o), 32'd1);
    check("rst done", 32'(done_o), 32'd0);
    check("rst err", 32'(err_o), 32'd0);
    check("rst result", result_o, 32'd0);
    check("rst be", 32'(mem.data_be_o), 32'd0);
    check("rst we", 32'(mem.data_we_o), 32'd0);
    check("rst addr", mem.data_addr_o, 32'd0);
    check("rst wdata", mem.data_wdata_o, 32'd0);
    check("rst state", 32'(state_o), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_txn("SW", LOAD_NONE, STORE_SW, 32'h1004, 32'hDEADBEEF, 32'h0, 0,
           4'b1111, 32'hDEADBEEF, model_result);
    do_txn("LB", LOAD_LB, STORE_NONE, 32'h2003, 32'h0, 32'h80112233, 0,
           4'b1000, 32'h0, 32'hFFFFFF80);
    do_txn("LBU", LOAD_LBU, STORE_NONE, 32'h2003, 32'h0, 32'h80112233, 1,
           4'b1000, 32'h0, 32'h00000080);
    do_txn("LH", LOAD_LH, STORE_NONE, 32'h2002, 32'h0, 32'h80011234, 3,
           4'b1100, 32'h0, 32'hFFFF8001);

    do_err("SH mis", LOAD_NONE, STORE_SH, 32'h3001);
    do_err("LW mis", LOAD_LW, STORE_NONE, 32'h3002);
    do_err("both", LOAD_LB, STORE_SB, 32'h10);

    // Neither load nor store: silently ignored.
    valid_i = 1'b1; addr_i = 32'h44;
    tick();
    valid_i = 1'b0;
    check("none err", 32'(err_o), 32'd0);
    check_idle_outputs("none");

    do_txn("SB", LOAD_NONE, STORE_SB, 32'h11, 32'h000000AB, 32'h0, 0,
           4'b0010, 32'hABABABAB, model_result);
    do_txn("SH", LOAD_NONE, STORE_SH, 32'h22, 32'h1234CAFE, 32'h0, 2,
           4'b1100, 32'hCAFECAFE, model_result);
    do_txn("LHU", LOAD_LHU, STORE_NONE, 32'h2000, 32'h0, 32'h1234F00D, 0,
           4'b0011, 32'h0, 32'h0000F00D);
    do_txn("LB0", LOAD_LB, STORE_NONE, 32'h2001, 32'h0, 32'h00007F00, 0,
           4'b0010, 32'h0, 32'h0000007F);

    // Reset while waiting for rvalid, then a stray rvalid after release.
    load_type_i = LOAD_LW; addr_i = 32'h40; valid_i = 1'b1;
    tick();
    valid_i = 1'b0; load_type_i = 3'b000;
    mem.data_gnt_i = 1'b1;
    tick();
    mem.data_gnt_i = 1'b0;
    check("abort state", 32'(state_o), 32'(ST_WAIT_R));
    #2 rst_n = 1'b0;
    #1;
    check("abort req", 32'(mem.data_req_o), 32'd0);
    check("abort ready", 32'(ready_o), 32'd1);
    check("abort result", result_o, 32'd0);
    check("abort be", 32'(mem.data_be_o), 32'd0);
    check("abort state idle", 32'(state_o), 32'(ST_IDLE));
    model_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem.data_rvalid_i = 1'b1; mem.data_rdata_i = 32'hFFFFFFFF;
    tick();
    mem.data_rvalid_i = 1'b0;
    check("stray done", 32'(done_o), 32'd0);
    check("stray result", result_o, 32'd0);
    check_idle_outputs("stray");
    do_txn("LW", LOAD_LW, STORE_NONE, 32'h44, 32'h0, 32'h12345678, 0,
           4'b1111, 32'h0, 32'h12345678);

    check("queue empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
